ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Single-port RAM-side responder for the shared system bus.
- Bus masters are the CPU and the dma block; both drive Address, DataIn, Cs, Wena and Oen.
- Services reads and writes with a registered read path.
- Holds a special-register region at the bottom of the address map. This region drives board-level outputs: switch bank and temperature 7-segment display.
- General-purpose storage occupies the remaining address space.

Parameters:
- SPECIAL_TOP, 8'h3F, highest address of the special-register region (0x00..SPECIAL_TOP).
- TEMP_ADDR, 8'h31, address of the temperature register.
- TEMP_RESET, 8'h14, reset value of the temperature register (20 decimal).
- SW_BASE, 8'h10, first of 8 switch registers (SW_BASE..SW_BASE+7).

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- Cs  in  1  chip select; all accesses are ignored while low.
- Wena  in  1  write enable, sampled with Cs.
- Oen  in  1  output enable (read request), sampled with Cs.
- Address  in  8  byte address.
- DataIn  in  8  write data from the bus master.
- DataOut  out  8  registered read data.
- Switches  out  8  Switches[i] = bit0 of register SW_BASE+i.
- Temp_H  out  7  tens-digit segment code, gfedcba, active-high.
- Temp_L  out  7  units-digit segment code, gfedcba, active-high.

Behaviour:
- One clock (Clk, rising edge); reset is asynchronous and active-low (Rst_n). Rst_n low forces all state immediately.
- Reset values:
  - DataOut = 8'h00.
  - All special registers = 8'h00, except TEMP_ADDR = TEMP_RESET.
  - Switches = 8'h00; Temp_H/Temp_L show "20".
  - General-purpose array (SPECIAL_TOP+1..0xFF) is NOT reset; contents are retained across reset.
- Write: at a rising edge with Cs=1 and Wena=1, mem[Address] <= DataIn. The written value is visible on Switches/Temp outputs from the next cycle.
- Read: at a rising edge with Cs=1, Oen=1 and Wena=0, DataOut <= mem[Address]. Latency is 1 cycle; data is valid in the cycle after the request.
- DataOut holds its last value when no read is issued (including Cs=0).
- Cs=1 with Wena=1 and Oen=1: the write wins and DataOut holds (no read-during-write).
- Cs=1 with Wena=0 and Oen=0: no-op.
- Back-to-back accesses are allowed every cycle with no wait states.
- Read-after-write to the same address in the next cycle returns the new data.
- Addresses inside the special region other than switch and temperature registers behave as plain storage. The CPU and dma use them as mailboxes and buffers.
- Temperature decode, combinational from the TEMP_ADDR register value T:
  - T <= 99: Temp_H = seg(T/10), Temp_L = seg(T%10).
  - T > 99: both digits show dash, 7'b1000000.
  - Segment codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
- Reset asserted mid-access: the access is abandoned and no write occurs. After deassertion the first edge is a normal cycle.
- The address map fits exactly in 8 bits; there is no wrap-around or out-of-range case.

Test Plan:
- Reset, no access -> DataOut=00, Switches=00, Temp_H=5B ("2"), Temp_L=3F ("0").
- Write 8'hA5 to 0x80, read 0x80 next cycle -> DataOut=A5 exactly one cycle after the read request; DataOut unchanged while Cs=0.
- Write 8'h01 to 0x10, 0x13 and 0x17; write 8'hFE to 0x11 -> Switches=8'b1000_1001.
- Write 8'd57 to 0x31 -> Temp_H=6D, Temp_L=07. Write 8'd100 -> both 40. Write 8'd0 -> both 3F.
- Read 0x80 (=A5), then Cs=1 with Wena=1, Oen=1 writing 8'h3C to 0x80 -> DataOut stays A5; next read returns 3C.
- Write 8'h11 to 0x40, pulse Rst_n low mid-write of 8'h22 to 0x40 -> read 0x40 returns 11; special registers are back at reset values.

Source files
------------

// File: rtl/ram_responder_if.sv
// Shared system-bus view of the RAM responder: CPU/dma masters drive the
// request side, the responder returns registered read data.
`timescale 1ns/1ps
interface ram_responder_if;
  logic       Cs;
  logic       Wena;
  logic       Oen;
  logic [7:0] Address;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  modport master (
    output Cs, Wena, Oen, Address, DataIn,
    input  DataOut
  );

  modport slave (
    input  Cs, Wena, Oen, Address, DataIn,
    output DataOut
  );
endinterface

// File: rtl/ram_responder.sv
// RAM-side bus responder: a resettable special-register window (switches,
// temperature display, mailboxes) below general-purpose storage that survives reset.
`timescale 1ns/1ps
module ram_responder #(
  parameter logic [7:0] SPECIAL_TOP = 8'h3F,
  parameter logic [7:0] TEMP_ADDR   = 8'h31,
  parameter logic [7:0] TEMP_RESET  = 8'h14,
  parameter logic [7:0] SW_BASE     = 8'h10
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  ram_responder_if.slave        bus,
  output logic [7:0]            Switches,
  output logic [6:0]            Temp_H,
  output logic [6:0]            Temp_L
);

  localparam int SPECIAL_DEPTH = int'(SPECIAL_TOP) + 1;
  localparam int GP_DEPTH      = 256 - SPECIAL_DEPTH;
  localparam int SP_AW         = $clog2(SPECIAL_DEPTH);
  localparam int GP_AW         = $clog2(GP_DEPTH);
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  logic             write_en;
  logic             read_en;
  logic             in_special;
  logic [SP_AW-1:0] sp_index;
  logic [GP_AW-1:0] gp_index;

  logic [7:0] special_reg [SPECIAL_DEPTH];
  logic [7:0] gp_mem      [GP_DEPTH];
  logic [7:0] data_out_reg;
  logic [7:0] data_out_next;

  // A simultaneous write and read request is treated as a write only.
  assign write_en   = bus.Cs & bus.Wena;
  assign read_en    = bus.Cs & bus.Oen & ~bus.Wena;
  assign in_special = (bus.Address <= SPECIAL_TOP);
  assign sp_index   = bus.Address[SP_AW-1:0];
  assign gp_index   = GP_AW'(bus.Address - (SPECIAL_TOP + 8'd1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < SPECIAL_DEPTH; i++) begin
        special_reg[i] <= (i == int'(TEMP_ADDR)) ? TEMP_RESET : 8'h00;
      end
    end else if (write_en && in_special) begin
      special_reg[sp_index] <= bus.DataIn;
    end
  end

  // General storage has no reset; Rst_n only blocks a write caught by reset.
  always_ff @(posedge Clk) begin
    if (Rst_n && write_en && !in_special) begin
      gp_mem[gp_index] <= bus.DataIn;
    end
  end

  always_comb begin
    data_out_next = data_out_reg;
    if (read_en) begin
      data_out_next = in_special ? special_reg[sp_index] : gp_mem[gp_index];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_out_reg <= 8'h00;
    end else begin
      data_out_reg <= data_out_next;
    end
  end

  assign bus.DataOut = data_out_reg;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_switch
      assign Switches[gi] = special_reg[int'(SW_BASE) + gi][0];
    end
  endgenerate

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

  logic [7:0] temp_value;
  logic [7:0] tens_digit;
  logic [7:0] units_digit;

  assign temp_value  = special_reg[SP_AW'(TEMP_ADDR)];
  assign tens_digit  = temp_value / 8'd10;
  assign units_digit = temp_value % 8'd10;

  always_comb begin
    Temp_H = SEG_DASH;
    Temp_L = SEG_DASH;
    if (temp_value <= 8'd99) begin
      Temp_H = seg_code(tens_digit[3:0]);
      Temp_L = seg_code(units_digit[3:0]);
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: bus accesses with hand-computed expectations.
`timescale 1ns/1ps
module tb_ram_responder;

  logic       Clk;
  logic       Rst_n;
  logic [7:0] Switches;
  logic [6:0] Temp_H;
  logic [6:0] Temp_L;

  int checks_total;
  int checks_passed;

  ram_responder_if bus_if ();

  ram_responder dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .bus      (bus_if),
    .Switches (Switches),
    .Temp_H   (Temp_H),
    .Temp_L   (Temp_L)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end else begin
      checks_passed++;
      $display("ok   %s: %02h", tag, got);
    end
  endtask

  // Drive one bus cycle, then return 1 ns after the edge that samples it.
  task automatic bus_cycle(input logic cs, input logic we, input logic oe,
                           input logic [7:0] addr, input logic [7:0] din);
    bus_if.Cs      = cs;
    bus_if.Wena    = we;
    bus_if.Oen     = oe;
    bus_if.Address = addr;
    bus_if.DataIn  = din;
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] din);
    bus_cycle(1'b1, 1'b1, 1'b0, addr, din);
  endtask

  task automatic rd(input logic [7:0] addr);
    bus_cycle(1'b1, 1'b0, 1'b1, addr, 8'h00);
  endtask

  task automatic idle();
    bus_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    Rst_n          = 1'b0;
    bus_if.Cs      = 1'b0;
    bus_if.Wena    = 1'b0;
    bus_if.Oen     = 1'b0;
    bus_if.Address = 8'h00;
    bus_if.DataIn  = 8'h00;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("reset DataOut",  bus_if.DataOut, 8'h00);
    check("reset Switches", Switches,       8'h00);
    check("reset Temp_H",   {1'b0, Temp_H}, 8'h5B);
    check("reset Temp_L",   {1'b0, Temp_L}, 8'h3F);
    Rst_n = 1'b1;
    idle();

    // Basic write/read with one-cycle read latency
    wr(8'h80, 8'hA5);
    check("DataOut holds after write", bus_if.DataOut, 8'h00);
    rd(8'h80);
    check("read 0x80", bus_if.DataOut, 8'hA5);
    bus_cycle(1'b0, 1'b1, 1'b0, 8'h80, 8'hFF);
    check("DataOut holds Cs=0", bus_if.DataOut, 8'hA5);
    bus_cycle(1'b1, 1'b0, 1'b0, 8'h81, 8'h00);
    check("DataOut holds no-op", bus_if.DataOut, 8'hA5);
    rd(8'h80);
    check("Cs=0 write ignored", bus_if.DataOut, 8'hA5);

    // Switch bank
    wr(8'h10, 8'h01);
    wr(8'h13, 8'h01);
    wr(8'h17, 8'h01);
    wr(8'h11, 8'hFE);
    idle();
    check("Switches", Switches, 8'h89);

    // Temperature display
    wr(8'h31, 8'd57);
    check("Temp_H 57", {1'b0, Temp_H}, 8'h6D);
    check("Temp_L 57", {1'b0, Temp_L}, 8'h07);
    wr(8'h31, 8'd99);
    check("Temp_H 99", {1'b0, Temp_H}, 8'h6F);
    check("Temp_L 99", {1'b0, Temp_L}, 8'h6F);
    wr(8'h31, 8'd100);
    check("Temp_H 100", {1'b0, Temp_H}, 8'h40);
    check("Temp_L 100", {1'b0, Temp_L}, 8'h40);
    wr(8'h31, 8'd0);
    check("Temp_H 0", {1'b0, Temp_H}, 8'h3F);
    check("Temp_L 0", {1'b0, Temp_L}, 8'h3F);

    // Write wins over a simultaneous read
    rd(8'h80);
    check("read 0x80 pre", bus_if.DataOut, 8'hA5);
    bus_cycle(1'b1, 1'b1, 1'b1, 8'h80, 8'h3C);
    check("write+read holds", bus_if.DataOut, 8'hA5);
    rd(8'h80);
    check("read-after-write", bus_if.DataOut, 8'h3C);

    // Region boundaries
    wr(8'h3F, 8'h5A);
    rd(8'h3F);
    check("mailbox 0x3F", bus_if.DataOut, 8'h5A);
    wr(8'h40, 8'h11);
    rd(8'h40);
    check("gp 0x40", bus_if.DataOut, 8'h11);
    wr(8'hFF, 8'hC3);
    rd(8'hFF);
    check("gp 0xFF", bus_if.DataOut, 8'hC3);

    // Reset pulsed in the middle of a write to 0x40
    bus_if.Cs      = 1'b1;
    bus_if.Wena    = 1'b1;
    bus_if.Oen     = 1'b0;
    bus_if.Address = 8'h40;
    bus_if.DataIn  = 8'h22;
    #3;
    Rst_n = 1'b0;
    #1;
    check("async reset DataOut",  bus_if.DataOut, 8'h00);
    check("async reset Switches", Switches,       8'h00);
    @(posedge Clk);
    #1;
    check("reset Temp_H again", {1'b0, Temp_H}, 8'h5B);
    check("reset Temp_L again", {1'b0, Temp_L}, 8'h3F);
    bus_if.Cs   = 1'b0;
    bus_if.Wena = 1'b0;
    #1;
    Rst_n = 1'b1;
    rd(8'h40);
    check("0x40 kept after reset", bus_if.DataOut, 8'h11);
    rd(8'h80);
    check("0x80 kept after reset", bus_if.DataOut, 8'h3C);
    rd(8'h3F);
    check("0x3F cleared by reset", bus_if.DataOut, 8'h00);
    rd(8'h31);
    check("temp reg reset value", bus_if.DataOut, 8'h14);
    rd(8'h10);
    check("switch reg cleared", bus_if.DataOut, 8'h00);
    idle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
